// File: rtl/seg_link_pkg.sv
// -----------------------------------------------------------------------------
// seg_link_pkg
// Shared definitions for the 74HC595 seven-segment link:
//   - default segment/select widths
//   - segment bit positions inside the {dp,g,f,e,d,c,b,a} byte
//   - a..g patterns for hex digits 0..F (active-high, bit 0 = a)
//   - decode_ag(): a..g pattern -> hex value plus blank/bad flags
// -----------------------------------------------------------------------------
package seg_link_pkg;

  localparam int DEF_SEG_W = 8;
  localparam int DEF_SEL_W = 6;

  // Bit positions inside the segment byte.
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // No segment a..g lit.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Standard seven-segment shapes, b and d drawn lowercase.
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] val;
    logic       blank;
    logic       bad;
  } seg_dec_t;

  // Blank and unknown patterns both report value 0.
  function automatic seg_dec_t decode_ag(input logic [6:0] ag);
    seg_dec_t d;
    d = '0;
    if (ag == SEG_BLANK) begin
      d.blank = 1'b1;
    end else begin
      d.bad = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (ag == HEX_PAT[i]) begin
          d.val = 4'(i);
          d.bad = 1'b0;
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings one asynchronous link line into the clk domain.
//   clk, reset_n : system clock, async active-low reset
//   i_d          : raw asynchronous input
//   o_level      : synchronized level (second synchronizer stage)
//   o_rise       : one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // NOTE: sequential state uses non-blocking assignments so the three stages
  // really form a pipeline instead of collapsing into one flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/hc595_seg_monitor.sv
// -----------------------------------------------------------------------------
// hc595_seg_monitor
// Receiver/checker for the serial 74HC595 seven-segment link. Oversamples the
// link on clk, rebuilds each latched {seg, sel} frame, flags length and
// digit-select errors, decodes the digit and keeps a shadow of the display.
//   clk, reset_n        : system clock, async active-low reset
//   ds, shcp, stcp, oe  : link lines (asynchronous to clk)
//   frame_valid         : one-cycle pulse per stcp rise
//   frame_data          : latched frame {seg, sel}
//   len_err, sel_err    : frame length / select errors, held until next latch
//   digit_idx/val/dp    : selected digit, decoded hex value, decimal point
//   digit_blank/bad     : no a..g lit / a..g pattern not a hex digit
//   disp_hex, disp_mask : display shadow (4 bits per digit), digits written
//   blanked             : synchronized oe is high
// -----------------------------------------------------------------------------
module hc595_seg_monitor
  import seg_link_pkg::*;
#(
  parameter int SEG_W       = DEF_SEG_W,
  parameter int SEL_W       = DEF_SEL_W,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ds,
  input  logic                   shcp,
  input  logic                   stcp,
  input  logic                   oe,
  output logic                   frame_valid,
  output logic [SEG_W+SEL_W-1:0] frame_data,
  output logic                   len_err,
  output logic                   sel_err,
  output logic [2:0]             digit_idx,
  output logic [3:0]             digit_val,
  output logic                   digit_dp,
  output logic                   digit_blank,
  output logic                   digit_bad,
  output logic [4*SEL_W-1:0]     disp_hex,
  output logic [SEL_W-1:0]       disp_mask,
  output logic                   blanked
);

  localparam int         FRAME_W  = SEG_W + SEL_W;
  localparam logic [4:0] CNT_MAX  = 5'd31;
  localparam logic [4:0] CNT_FULL = 5'(FRAME_W);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic w_ds_lvl,   w_ds_rise;
  logic w_shcp_lvl, w_shcp_rise;
  logic w_stcp_lvl, w_stcp_rise;
  logic w_oe_lvl,   w_oe_rise;

  edge_sync u_sync_ds   (.clk(clk), .reset_n(reset_n), .i_d(ds),   .o_level(w_ds_lvl),   .o_rise(w_ds_rise));
  edge_sync u_sync_shcp (.clk(clk), .reset_n(reset_n), .i_d(shcp), .o_level(w_shcp_lvl), .o_rise(w_shcp_rise));
  edge_sync u_sync_stcp (.clk(clk), .reset_n(reset_n), .i_d(stcp), .o_level(w_stcp_lvl), .o_rise(w_stcp_rise));
  edge_sync u_sync_oe   (.clk(clk), .reset_n(reset_n), .i_d(oe),   .o_level(w_oe_lvl),   .o_rise(w_oe_rise));

  // Only the ds/oe levels and the shcp/stcp edges are meaningful.
  logic w_unused;
  assign w_unused = ^{w_ds_rise, w_shcp_lvl, w_stcp_lvl, w_oe_rise};

  // ---------------------------------------------------------------------------
  // Shift register, counter and latched frame
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] r_sr;
  logic [4:0]         r_cnt;
  logic               r_frame_valid;
  logic [FRAME_W-1:0] r_frame_data;
  logic               r_len_err;
  logic               r_sel_err;
  logic [2:0]         r_digit_idx;
  logic [3:0]         r_digit_val;
  logic               r_digit_dp;
  logic               r_digit_blank;
  logic               r_digit_bad;
  logic               r_blanked;

  // Decode of the frame about to be latched (current r_sr), so the digit
  // fields are registered together with frame_data.
  logic [SEG_W-1:0] w_seg_on;
  logic [SEL_W-1:0] w_sel_on;
  logic             w_sel_err;
  logic [2:0]       w_idx;
  seg_dec_t         w_dec;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_seg_on  = SEG_ACT_LOW ? ~r_sr[FRAME_W-1:SEL_W] : r_sr[FRAME_W-1:SEL_W];
    w_sel_on  = SEL_ACT_LOW ? ~r_sr[SEL_W-1:0]       : r_sr[SEL_W-1:0];
    w_sel_err = !$onehot(w_sel_on);
    w_idx     = 3'd0;
    if (!w_sel_err) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (w_sel_on[i]) w_idx = 3'(i);
      end
    end
    w_dec = decode_ag(w_seg_on[SEG_G:SEG_A]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr          <= '0;
      r_cnt         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_data  <= '0;
      r_len_err     <= 1'b0;
      r_sel_err     <= 1'b0;
      r_digit_idx   <= '0;
      r_digit_val   <= '0;
      r_digit_dp    <= 1'b0;
      r_digit_blank <= 1'b0;
      r_digit_bad   <= 1'b0;
      r_blanked     <= 1'b0;
    end else begin
      r_frame_valid <= w_stcp_rise;
      r_blanked     <= w_oe_lvl;

      // Shift happens even when stcp rises in the same cycle; the latch below
      // still sees the pre-shift value, as the real part does with tied clocks.
      if (w_shcp_rise) r_sr <= {r_sr[FRAME_W-2:0], w_ds_lvl};

      if (w_stcp_rise) begin
        r_frame_data  <= r_sr;
        r_len_err     <= (r_cnt != CNT_FULL);
        r_sel_err     <= w_sel_err;
        r_digit_idx   <= w_idx;
        r_digit_val   <= w_dec.val;
        r_digit_dp    <= w_seg_on[SEG_DP];
        r_digit_blank <= w_dec.blank;
        r_digit_bad   <= w_dec.bad;
        r_cnt         <= w_shcp_rise ? 5'd1 : 5'd0;
      end else if (w_shcp_rise && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display shadow, updated the cycle after a clean latch
  // ---------------------------------------------------------------------------
  logic [4*SEL_W-1:0] r_disp_hex;
  logic [SEL_W-1:0]   r_disp_mask;

  // NOTE: the shadow is a handful of flops rather than a RAM, so it can take
  // the asynchronous reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_hex  <= '0;
      r_disp_mask <= '0;
    end else if (r_frame_valid && !r_len_err && !r_sel_err &&
                 !r_digit_bad && !r_digit_blank) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (r_digit_idx == 3'(i)) begin
          r_disp_hex[4*i +: 4] <= r_digit_val;
          r_disp_mask[i]       <= 1'b1;
        end
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_data  = r_frame_data;
  assign len_err     = r_len_err;
  assign sel_err     = r_sel_err;
  assign digit_idx   = r_digit_idx;
  assign digit_val   = r_digit_val;
  assign digit_dp    = r_digit_dp;
  assign digit_blank = r_digit_blank;
  assign digit_bad   = r_digit_bad;
  assign disp_hex    = r_disp_hex;
  assign disp_mask   = r_disp_mask;
  assign blanked     = r_blanked;

endmodule

// File: doc/hc595_seg_monitor.md
# hc595_seg_monitor

Synthesizable receiver for the serial 74HC595 seven-segment link (`ds`, `shcp`, `stcp`, `oe`) driven by the game top. It oversamples the four link lines on the system clock, rebuilds each latched frame, and checks frame length and digit-select validity. It decodes the segment pattern back into a hex digit and keeps a per-digit shadow of the displayed number. It serves as an on-chip/loopback checker and as the bench-side decoder of the score display.

## Interface
Parameters:
- `SEG_W`, 8: segment bits `{dp,g,f,e,d,c,b,a}`.
- `SEL_W`, 6: digit-select bits.
- `SEG_ACT_LOW`, 1: a segment is lit when its bit is 0.
- `SEL_ACT_LOW`, 0: the selected digit's bit is 1 (one-hot, active-high).

Ports:
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `ds` in 1: serial data, asynchronous to `clk`.
- `shcp` in 1: shift clock; its rising edge shifts `ds` in.
- `stcp` in 1: storage clock; its rising edge latches the frame.
- `oe` in 1: output enable, active-low.
- `frame_valid` out 1: one-cycle pulse per `stcp` rise.
- `frame_data` out `SEG_W+SEL_W`: latched frame, `{seg, sel}`.
- `len_err` out 1: shift count ≠ `SEG_W+SEL_W` at latch. Valid with `frame_valid`, held until the next latch.
- `sel_err` out 1: `sel` not one-hot. Same validity and hold as `len_err`.
- `digit_idx` out 3: index of the selected digit.
- `digit_val` out 4: decoded hex value.
- `digit_dp` out 1: decimal point lit.
- `digit_blank` out 1: no segments a–g lit.
- `digit_bad` out 1: a–g pattern is not in the hex table.
- `disp_hex` out `4*SEL_W`: shadow of the display; digit i occupies `[4i+3:4i]`.
- `disp_mask` out `SEL_W`: digits written since reset.
- `blanked` out 1: synchronized `oe` is high.

## Operation
- **Synchronizer.** Each input passes through 2 flops, then a history flop. `rise_x = s2_x & ~s3_x`. `ds` is taken from `s2_ds` in the same cycle as `rise_shcp`.
- **Shift.** On `rise_shcp`: `sr <= {sr[N-2:0], s2_ds}`, where N = `SEG_W+SEL_W`. The first bit shifted ends in the MSB after N shifts. `cnt` increments and saturates at 31 (5 bits).
- **Latch.** On `rise_stcp`:
  - `frame_data <= sr` (the value before any shift in that cycle).
  - `len_err <= (cnt != N)`.
  - `cnt <= rise_shcp ? 1 : 0`.
  - `frame_valid` pulses in the same update.
- **Simultaneous `shcp`/`stcp` rise.** The latch takes the old `sr` and the shift still happens, matching the 74HC595 behaviour with tied clocks.
- **Decode.** Decoding is combinational on `frame_data` and registered with the latch, so the digit outputs are valid alongside `frame_valid`.
  - Normalize polarity via the `SEG_ACT_LOW` and `SEL_ACT_LOW` parameters.
  - a–g map to 0–F using the standard patterns; b and d are lowercase.
  - All off → `digit_blank=1`, `digit_val=0`.
  - Unknown pattern → `digit_bad=1`, `digit_val=0`.
  - `digit_idx` is the position of the set `sel` bit, or 0 when `sel_err`.
- **Shadow.** On a latch with `!len_err && !sel_err && !digit_bad && !digit_blank`:
  - write `digit_val` into `disp_hex[digit_idx]`;
  - set `disp_mask[digit_idx]`.
  - Otherwise leave the shadow unchanged.
- **`oe`.** `oe` only drives `blanked`. Frames are still captured while `oe` is high.

## Timing
- **Latency.** An input edge reaches `sr`/`frame_*` 3 `clk` rising edges after it is first sampled, i.e. 2 synchronizer stages plus the edge/register stage. Shadow outputs follow 1 cycle after `frame_valid`.
- **Minimum input pulse.** Minimum `shcp`/`stcp` high or low time is 2 `clk` periods (40 ns). Shorter pulses may be missed; no detection is required.
- **`ds` setup.** `ds` must be stable ≥1 `clk` before `shcp` rises.
- **Reset values.** All outputs reset to 0: `frame_valid`, `frame_data`, `len_err`, `sel_err`, `digit_*`, `disp_hex`, `disp_mask`, `blanked`. Synchronizer flops and `cnt` also reset to 0.
- **Reset mid-frame.** The partial frame is discarded. After release, the first `stcp` reports `len_err` unless the following stream is a full N bits.
- **Counter saturation.** The saturated `cnt` (e.g. >31 shifts) always gives `len_err=1`.

## Structure
- Shared package `seg_link_pkg`:
  - `SEG_W`/`SEL_W` defaults;
  - segment bit positions;
  - 16-entry a–g hex pattern constants;
  - `SEG_BLANK`.
- Sub-module `edge_sync`, one instance per link line. It contains the 2-flop synchronizer and history flop and outputs the synced level and a rise pulse.
- The decoder is a function in the package. It is not a separate module.

## Test plan
- **Single digit.** Shift 14 bits, frame `{seg=8'hC0, sel=6'b000001}` with active-low segments (digit "0"), then pulse `stcp`.
  - `frame_valid` 1 cycle, `frame_data=14'h3001`, `digit_idx=0`, `digit_val=0`, no errors.
  - One cycle later: `disp_mask=6'b000001`.
- **Score scan.** Six frames showing "123456" across `sel` bits 0–5 → `disp_hex=24'h654321`, `disp_mask=6'h3F`.
- **Length error.** 13 shifts then `stcp` → `len_err=1`, shadow unchanged. Then 40 shifts then `stcp` → `len_err=1` with `cnt` saturated.
- **Select error and blank.** `sel=6'b000011` → `sel_err=1`, `digit_idx=0`. `seg=8'hFF` → `digit_blank=1`. Neither updates the shadow.
- **Tied clocks.** `shcp` and `stcp` rise together on the 15th shift → latched frame equals the first 14 bits, `len_err=0`, next-frame `cnt=1`.
- **Reset and `oe`.** Assert `reset_n=0` mid-frame → all outputs are 0 within the same cycle. Drive `oe=1` → `blanked=1` 3 cycles later, and capture continues.
